// File: rtl/simple_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_t : FSM encoding (RUN / INWAIT / HALTED, 2'b11 unused)
//   REG_W   : width of a register-file index field
package simple_pkg;

  localparam int REG_W = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_INWAIT = 2'b01,
    ST_HALTED = 2'b10,
    ST_BAD    = 2'b11
  } state_t;

endpackage

// File: rtl/luse_detect.sv
// Load-use hazard detector (pure combinational).
// Flags when the instruction in EX is a load whose destination is a source
// register actually read by the instruction in ID.
//   id_rs, id_rt         : ID source register fields
//   id_use_rs, id_use_rt : ID instruction reads rs / rt
//   ex_memread, ex_rd    : EX instruction is a load, its destination
//   hit                  : load-use hazard present
module luse_detect
  import simple_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  output logic             hit
);

  assign hit = ex_memread &&
               ((id_use_rs && (id_rs == ex_rd)) ||
                (id_use_rt && (id_rt == ex_rd)));

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Pipeline hazard / stall controller.
// Produces PC, IF/ID and back-end pipeline write enables plus bubble
// (flush) controls from the hazard inputs, tracks halt and external-input
// wait in a small FSM, and counts stalled cycles.
//   clk, rst              : clock, synchronous active-high reset
//   id_rs/rt, id_use_rs/rt: ID instruction source fields and usage
//   ex_memread, ex_rd     : EX load flag and destination
//   br_taken              : branch resolved taken in EX
//   halt_ex               : HLT in EX
//   in_req, in_valid      : IN instruction in MEM, external data valid
//   restart               : resume request while halted
//   pc_we/ifid_we/pipe_we : register write enables
//   ifid_flush/idex_flush : bubble insertion
//   halted, state         : FSM status
//   stall_cnt             : saturating count of non-halted cycles with pc_we=0
module pipe_hazard_ctl
  import simple_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             br_taken,
  input  logic             halt_ex,
  input  logic             in_req,
  input  logic             in_valid,
  input  logic             restart,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             pipe_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t     state_q, state_d;
  logic       luse_hit;
  logic       in_stall;

  assign in_stall = in_req && !in_valid;

  luse_detect u_luse (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_use_rs  (id_use_rs),
    .id_use_rt  (id_use_rt),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .hit        (luse_hit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = ST_RUN;
    case (state_q)
      ST_RUN: begin
        if (halt_ex)       state_d = ST_HALTED;
        else if (in_stall) state_d = ST_INWAIT;
        else               state_d = ST_RUN;
      end
      ST_INWAIT: state_d = in_valid ? ST_RUN : ST_INWAIT;
      ST_HALTED: state_d = restart  ? ST_RUN : ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // Output logic. A taken branch that coincides with an input wait is not
  // acted on: the whole pipe freezes, so EX re-presents it once the wait ends.
  always_comb begin
    pc_we      = 1'b0;
    ifid_we    = 1'b0;
    pipe_we    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (halt_ex) begin
          pipe_we    = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (in_stall) begin
          // everything frozen
        end else if (br_taken) begin
          pc_we      = 1'b1;
          ifid_we    = 1'b1;
          pipe_we    = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (luse_hit) begin
          pipe_we    = 1'b1;
          idex_flush = 1'b1;
        end else begin
          pc_we      = 1'b1;
          ifid_we    = 1'b1;
          pipe_we    = 1'b1;
        end
      end
      ST_INWAIT: begin
        pc_we   = in_valid;
        ifid_we = in_valid;
        pipe_we = in_valid;
      end
      default: ;  // HALTED and the unused code keep everything idle
    endcase
    if (rst) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      pipe_we    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end
  end

  assign state  = state_q;
  assign halted = (state_q == ST_HALTED) && !rst;

  // Stall counter: saturates rather than wrapping so long runs stay meaningful.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (!pc_we && (state_q != ST_HALTED) && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: doc/pipe_hazard_ctl.md
PIPE_HAZARD_CTL -- requirements
Module: pipe_hazard_ctl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stall_cnt performance counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports id_rs, id_rt  input  3 each  source register fields of the instruction in ID.
REQ-005 SHALL have ports id_use_rs, id_use_rt  input  1 each  ID instruction reads rs / rt.
REQ-006 SHALL have port ex_memread  input  1  instruction in EX is a load (LD).
REQ-007 SHALL have port ex_rd  input  3  destination register of the EX instruction.
REQ-008 SHALL have port br_taken  input  1  branch resolved taken in EX this cycle.
REQ-009 SHALL have port halt_ex  input  1  HLT instruction is in EX.
REQ-010 SHALL have ports in_req, in_valid  input  1 each  IN instruction in MEM; external input data valid.
REQ-011 SHALL have port restart  input  1  external resume request while halted.
REQ-012 SHALL have ports pc_we, ifid_we, pipe_we  output  1 each  PC, IF/ID and ID/EX-EX/MEM-MEM/WB register write enables.
REQ-013 SHALL have ports ifid_flush, idex_flush  output  1 each  insert bubble into IF/ID, ID/EX.
REQ-014 SHALL have ports halted  output  1, state  output  2, stall_cnt  output  CNT_W.

Function
REQ-015 SHALL implement FSM states RUN=2'b00, INWAIT=2'b01, HALTED=2'b10; 2'b11 SHALL go to RUN.
REQ-016 SHALL derive enables combinationally from state and inputs; priority halt > input wait > branch > load-use.
REQ-017 In RUN, halt_ex SHALL give pc_we=0, ifid_we=0, pipe_we=1, ifid_flush=1, idex_flush=1, next state HALTED.
REQ-018 In RUN, in_req && !in_valid SHALL give pc_we=ifid_we=pipe_we=0, no flushes, next state INWAIT.
REQ-019 In RUN, br_taken SHALL give pc_we=1, ifid_we=1, pipe_we=1, ifid_flush=1, idex_flush=1 for that cycle only.
REQ-020 Load-use: ex_memread && ((id_use_rs && id_rs==ex_rd) || (id_use_rt && id_rt==ex_rd)) in RUN without branch SHALL give pc_we=0, ifid_we=0, pipe_we=1, idex_flush=1, one cycle.
REQ-021 In RUN with no event: pc_we=ifid_we=pipe_we=1, flushes 0.
REQ-022 In INWAIT, pc_we=ifid_we=pipe_we=in_valid; in_valid SHALL move to RUN next cycle, else stay.
REQ-023 In HALTED, all enables and flushes 0, halted=1; restart SHALL move to RUN next cycle; halt_ex ignored.
REQ-024 br_taken concurrent with in_req&&!in_valid SHALL be deferred (pipe frozen, branch re-presented on exit).
REQ-025 stall_cnt SHALL increment by 1 each cycle pc_we==0 and state!=HALTED, saturating at all-ones.
REQ-026 state output SHALL equal the registered FSM state; halted SHALL equal (state==HALTED).

Reset
REQ-027 rst SHALL override all inputs: next state RUN, stall_cnt=0.
REQ-028 While rst is high, outputs SHALL be pc_we=ifid_we=pipe_we=0, flushes=1, halted=0.
REQ-029 rst asserted in INWAIT or HALTED SHALL return to RUN on the next edge with no pending wait.

Structure
REQ-030 State encodings and register-field widths SHALL live in shared package simple_pkg.
REQ-031 Load-use compare SHALL be sub-module luse_detect (pure combinational); FSM and counter in top.

Verification
REQ-032 LD r3 in EX, ID reads rs=3 -> one cycle pc_we=0, idex_flush=1, stall_cnt 0->1.
REQ-033 br_taken=1 with load-use hit -> ifid_flush=idex_flush=1, pc_we=1, stall_cnt unchanged.
REQ-034 in_req=1, in_valid=0 for 4 cycles then 1 -> INWAIT 4 cycles, all enables 0, stall_cnt +4, RUN after.
REQ-035 halt_ex=1 -> flushes 1 that cycle, HALTED, halted=1; restart after 10 cycles -> RUN, stall_cnt +1 only.
REQ-036 CNT_W=4, 20 load-use stalls -> stall_cnt saturates at 4'hF.
REQ-037 rst=1 mid-INWAIT -> next cycle state=2'b00, stall_cnt=0.
